// File: rtl/pio_bank_if.sv
// CPU I/O bus bundle for pio_bank: write strobe, register select, write data,
// read strobe and registered read data.
interface pio_bank_if;
    logic        EN;
    logic [2:0]  addr;
    logic [31:0] P_Data;
    logic        rd_en;
    logic [31:0] rd_data;

    modport master (output EN, output addr, output P_Data, output rd_en, input rd_data);
    modport slave  (input EN, input addr, input P_Data, input rd_en, output rd_data);
endinterface

// File: rtl/pio_bank.sv
// pio_bank: parallel output bank driving LEDs, counter channel select and GPIO.
// Provides atomic LED set/clear/toggle writes and a divider-driven LED blink engine.
// Optional macro PIO_READBACK_EN adds registered readback on bus.rd_data;
// when the macro is undefined, rd_data is tied to zero.
module pio_bank #(
    parameter int unsigned       LED_W   = 16,
    parameter int unsigned       CS_W    = 2,
    parameter int unsigned       GP_W    = 14,
    parameter logic [LED_W-1:0]  LED_RST = 16'h002A,
    parameter int unsigned       DIV_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    pio_bank_if.slave         bus,
    output logic [CS_W-1:0]   counter_set,
    output logic [LED_W-1:0]  LED_out,
    output logic [GP_W-1:0]   GPIOf0
);

    if (LED_W + CS_W + GP_W > 32) begin : g_width_check
        $error("pio_bank: LED_W+CS_W+GP_W must not exceed 32");
    end

    typedef enum logic [2:0] {
        REG_PACK = 3'd0,
        REG_SET  = 3'd1,
        REG_CLR  = 3'd2,
        REG_TOG  = 3'd3,
        REG_MASK = 3'd4,
        REG_DIV  = 3'd5,
        REG_CNT  = 3'd6,
        REG_NONE = 3'd7
    } reg_e;

    reg_e sel;
    assign sel = reg_e'(bus.addr);

    logic [LED_W-1:0] led_q,   led_d;
    logic [CS_W-1:0]  cs_q,    cs_d;
    logic [GP_W-1:0]  gp_q,    gp_d;
    logic [LED_W-1:0] mask_q,  mask_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;
    logic             phase_q, phase_d;

    // Next-state: blink engine advance first, then bus writes override.
    always_comb begin
        led_d   = led_q;
        cs_d    = cs_q;
        gp_d    = gp_q;
        mask_d  = mask_q;
        div_d   = div_q;
        cnt_d   = '0;
        phase_d = 1'b0;

        if (div_q != '0) begin
            if (cnt_q == div_q) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + DIV_W'(1);
                phase_d = phase_q;
            end
        end

        if (bus.EN) begin
            unique case (sel)
                REG_PACK: begin
                    gp_d  = bus.P_Data[GP_W-1:0];
                    cs_d  = bus.P_Data[GP_W +: CS_W];
                    led_d = bus.P_Data[GP_W+CS_W +: LED_W];
                end
                REG_SET:  led_d  = led_q |  bus.P_Data[LED_W-1:0];
                REG_CLR:  led_d  = led_q & ~bus.P_Data[LED_W-1:0];
                REG_TOG:  led_d  = led_q ^  bus.P_Data[LED_W-1:0];
                REG_MASK: mask_d = bus.P_Data[LED_W-1:0];
                // A DIV write restarts the blink and beats a same-cycle terminal count.
                REG_DIV: begin
                    div_d   = bus.P_Data[DIV_W-1:0];
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset; a write during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= LED_RST;
            cs_q    <= '0;
            gp_q    <= '0;
            mask_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            cs_q    <= cs_d;
            gp_q    <= gp_d;
            mask_q  <= mask_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign counter_set = cs_q;
    assign GPIOf0      = gp_q;
    assign LED_out     = led_q ^ (mask_q & {LED_W{phase_q}});

`ifdef PIO_READBACK_EN
    logic [31:0] rd_data_q, rd_data_d;

    // Readback mux samples pre-write state, so a same-cycle write is not seen.
    always_comb begin
        rd_data_d = rd_data_q;
        if (bus.rd_en) begin
            rd_data_d = '0;
            unique case (sel)
                REG_PACK: begin
                    rd_data_d[GP_W-1:0]              = gp_q;
                    rd_data_d[GP_W +: CS_W]          = cs_q;
                    rd_data_d[GP_W+CS_W +: LED_W]    = led_q;
                end
                REG_SET, REG_CLR, REG_TOG: rd_data_d[LED_W-1:0] = led_q;
                REG_MASK: rd_data_d[LED_W-1:0] = mask_q;
                REG_DIV:  rd_data_d[DIV_W-1:0] = div_q;
                REG_CNT: begin
                    rd_data_d[DIV_W-1:0] = cnt_q;
                    rd_data_d[31]        = phase_q;
                end
                default: rd_data_d = '0;
            endcase
        end
    end

    // Read data register, cleared by reset, holds when no read is strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
`else
    logic unused_rd_en;
    assign unused_rd_en = bus.rd_en;
    assign bus.rd_data  = '0;
`endif

endmodule

// File: tb/tb_pio_bank.sv
// Self-checking bench for pio_bank: directed bus traffic, an abstract model
// (blink state derived from elapsed cycles since the last DIV write) and
// literal spot checks at the key points.
module tb_pio_bank;

    localparam int unsigned LED_W = 16;
    localparam int unsigned CS_W  = 2;
    localparam int unsigned GP_W  = 14;
    localparam int unsigned DIV_W = 24;

    logic clk = 1'b0;
    logic rst;
    logic [CS_W-1:0]  counter_set;
    logic [LED_W-1:0] LED_out;
    logic [GP_W-1:0]  GPIOf0;

    pio_bank_if bus ();

    pio_bank #(
        .LED_W   (LED_W),
        .CS_W    (CS_W),
        .GP_W    (GP_W),
        .LED_RST (16'h002A),
        .DIV_W   (DIV_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .counter_set (counter_set),
        .LED_out     (LED_out),
        .GPIOf0      (GPIOf0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- abstract model ----------------
    bit          m_valid = 0;
    logic [15:0] m_led, m_mask;
    logic [1:0]  m_cs;
    logic [13:0] m_gp;
    int unsigned m_div;
    int unsigned m_k;       // edges since blink restart
    logic [31:0] m_rd;

    function automatic int unsigned m_cnt();
        return (m_div == 0) ? 0 : m_k % (m_div + 1);
    endfunction

    function automatic bit m_phase();
        return (m_div == 0) ? 1'b0 : bit'((m_k / (m_div + 1)) % 2);
    endfunction

    always @(posedge clk) begin
        logic [31:0] d;
        int unsigned nk;
        d = bus.P_Data;
        if (rst) begin
            m_valid = 1;
            m_led = 16'h002A; m_mask = '0; m_cs = '0; m_gp = '0;
            m_div = 0; m_k = 0; m_rd = '0;
        end else if (m_valid) begin
`ifdef PIO_READBACK_EN
            if (bus.rd_en) begin
                case (bus.addr)
                    3'd0: m_rd = {m_led, m_cs, m_gp};
                    3'd1, 3'd2, 3'd3: m_rd = {16'h0, m_led};
                    3'd4: m_rd = {16'h0, m_mask};
                    3'd5: m_rd = m_div;
                    3'd6: m_rd = {m_phase(), 31'(m_cnt())};
                    default: m_rd = '0;
                endcase
            end
`endif
            nk = (m_div != 0) ? m_k + 1 : 0;
            if (bus.EN) begin
                case (bus.addr)
                    3'd0: begin m_led = d[31:16]; m_cs = d[15:14]; m_gp = d[13:0]; end
                    3'd1: m_led = m_led | d[15:0];
                    3'd2: m_led = m_led & ~d[15:0];
                    3'd3: m_led = m_led ^ d[15:0];
                    3'd4: m_mask = d[15:0];
                    3'd5: begin m_div = d[23:0]; nk = 0; end
                    default: ;
                endcase
            end
            m_k = nk;
        end
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("led_out", 32'(LED_out), 32'(m_led ^ (m_mask & {16{m_phase()}})));
            chk("counter_set", 32'(counter_set), 32'(m_cs));
            chk("gpio", 32'(GPIOf0), 32'(m_gp));
            chk("rd_data", bus.rd_data, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic en, input logic rden, input logic [2:0] a, input logic [31:0] d);
        bus.EN = en; bus.rd_en = rden; bus.addr = a; bus.P_Data = d;
        step();
        bus.EN = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [31:0] exp_rd;

    initial begin
        rst = 1'b1;
        bus.EN = 1'b1; bus.addr = 3'd0; bus.P_Data = 32'hFFFF_FFFF; bus.rd_en = 1'b0;
        idle(2);
        chk("rst_led", 32'(LED_out), 32'h0000_002A);
        chk("rst_cs", 32'(counter_set), 32'h0);
        chk("rst_gp", 32'(GPIOf0), 32'h0);
        chk("rst_rd", bus.rd_data, 32'h0);
        rst = 1'b0;
        bus.EN = 1'b0;
        idle(1);

        cyc(1, 0, 3'd0, 32'hBEEF_8005);
        chk("pack_led", 32'(LED_out), 32'h0000_BEEF);
        chk("pack_cs", 32'(counter_set), 32'h2);
        chk("pack_gp", 32'(GPIOf0), 32'h5);

        cyc(0, 1, 3'd0, 32'h0);
`ifdef PIO_READBACK_EN
        exp_rd = 32'hBEEF_8005;
`else
        exp_rd = 32'h0;
`endif
        chk("rd_pack", bus.rd_data, exp_rd);

        cyc(1, 0, 3'd0, 32'h00F0_0000);
        chk("led_f0", 32'(LED_out), 32'h0000_00F0);
        cyc(1, 0, 3'd1, 32'h0000_000F);
        chk("set", 32'(LED_out), 32'h0000_00FF);
        cyc(1, 0, 3'd2, 32'h0000_0011);
        chk("clr", 32'(LED_out), 32'h0000_00EE);
        cyc(1, 0, 3'd3, 32'h0000_FFFF);
        chk("tog", 32'(LED_out), 32'h0000_FF11);

        // Simultaneous write and read returns the old value
        cyc(1, 1, 3'd1, 32'h0000_00EE);
        chk("set_rw", 32'(LED_out), 32'h0000_FFFF);
`ifdef PIO_READBACK_EN
        exp_rd = 32'h0000_FF11;
`else
        exp_rd = 32'h0;
`endif
        chk("rd_old", bus.rd_data, exp_rd);
        cyc(0, 1, 3'd7, 32'h0);
        chk("rd_addr7", bus.rd_data, 32'h0);
        cyc(1, 1, 3'd6, 32'h1234_5678);   // reserved address: no state change
        cyc(1, 0, 3'd7, 32'hFFFF_FFFF);
        chk("rsv_led", 32'(LED_out), 32'h0000_FFFF);

        // Blink engine
        cyc(1, 0, 3'd0, 32'h0000_0000);
        cyc(1, 0, 3'd4, 32'h0000_0001);
        cyc(1, 0, 3'd5, 32'h0000_0003);
        idle(3);
        chk("blink_lo", 32'(LED_out), 32'h0);
        idle(1);
        chk("blink_hi", 32'(LED_out), 32'h1);
        idle(4);
        chk("blink_lo2", 32'(LED_out), 32'h0);
        idle(3);                           // cnt now at terminal count 3
        cyc(1, 0, 3'd5, 32'h0000_0003);    // rewrite wins over toggle
        chk("div_tc", 32'(LED_out), 32'h0);
        idle(3);
        chk("div_tc_lo", 32'(LED_out), 32'h0);
        idle(1);
        chk("div_tc_hi", 32'(LED_out), 32'h1);
        cyc(1, 0, 3'd4, 32'h0000_0003);    // mask rewrite keeps phase
        chk("mask_keep", 32'(LED_out), 32'h3);
        cyc(0, 1, 3'd6, 32'h0);
        cyc(0, 1, 3'd5, 32'h0);
        cyc(1, 0, 3'd3, 32'h0000_0100);    // TOG acts on stored value
        idle(5);
        cyc(1, 0, 3'd5, 32'h0000_0000);
        chk("div0", 32'(LED_out), 32'h0000_0100);
        idle(6);
        chk("div0_steady", 32'(LED_out), 32'h0000_0100);
        cyc(0, 1, 3'd6, 32'h0);
        chk("rd_cnt0", bus.rd_data, 32'h0);

        // Reset mid-blink
        cyc(1, 0, 3'd5, 32'h0000_0001);
        idle(3);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_led", 32'(LED_out), 32'h0000_002A);
        rst = 1'b0;
        cyc(0, 1, 3'd6, 32'h0);
        chk("mid_rst_cnt", bus.rd_data, 32'h0);
        idle(4);
        chk("mid_rst_steady", 32'(LED_out), 32'h0000_002A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
